// File: rtl/posit_pkg.sv
// Shared posit (N=32, ES=3) constants and FSM encodings.
// Used by both the decoder and the encoder.
package posit_pkg;

    localparam int N  = 32;
    localparam int ES = 3;
    localparam int KW = 6;

    localparam logic [N-1:0] ZERO = 32'h0000_0000;
    localparam logic [N-1:0] NAR  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SIGN   = 3'd1,
        S_REGIME = 3'd2,
        S_EXP    = 3'd3,
        S_MANT   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // Regime value from run polarity and run length.
    function automatic logic signed [KW-1:0] regime_k(
        input logic          ones,
        input logic [KW-1:0] len
    );
        return ones ? $signed(len - 6'd1) : $signed(-len);
    endfunction

endpackage

// File: rtl/posit_decoder.sv
// Bit-serial posit decoder: one body bit per cycle,
// sign-magnitude layout, result held until received.
module posit_decoder
    import posit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 received,
    input  logic [N-1:0]         posit_in,
    output logic                 sign_out,
    output logic signed [KW-1:0] k_out,
    output logic [ES-1:0]        exp_out,
    output logic [N-1:0]         mantissa_out,
    output logic                 is_zero,
    output logic                 is_nar,
    output logic                 done
);

    state_e        state_q;
    logic [N-1:0]  word_q;
    logic [4:0]    idx_q;
    logic [KW-1:0] run_q;
    logic [1:0]    ecnt_q;
    logic [4:0]    mptr_q;
    logic          hold_q;

    logic          cur_bit;
    logic          run_bit;
    logic [KW-1:0] run_d;
    logic          last;

    // Current body bit, regime polarity and next run length.
    always_comb begin
        cur_bit = word_q[idx_q];
        run_bit = word_q[N-2];
        run_d   = run_q + 6'd1;
        last    = (idx_q == 5'd0);
    end

    // Decode FSM walking the latched word from bit 31 down to bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            idx_q        <= 5'd31;
            run_q        <= '0;
            ecnt_q       <= '0;
            mptr_q       <= 5'd31;
            hold_q       <= 1'b0;
            sign_out     <= 1'b0;
            k_out        <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
            is_zero      <= 1'b0;
            is_nar       <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        word_q       <= posit_in;
                        idx_q        <= 5'd31;
                        run_q        <= '0;
                        ecnt_q       <= '0;
                        mptr_q       <= 5'd31;
                        sign_out     <= 1'b0;
                        k_out        <= '0;
                        exp_out      <= '0;
                        mantissa_out <= '0;
                        is_zero      <= 1'b0;
                        is_nar       <= 1'b0;
                        if (posit_in[N-2:0] == '0) begin
                            // Special words settle one extra cycle
                            is_zero <= (posit_in == ZERO);
                            is_nar  <= (posit_in == NAR);
                            hold_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_SIGN;
                        end
                    end
                end
                S_SIGN: begin
                    sign_out <= word_q[N-1];
                    idx_q    <= 5'd30;
                    state_q  <= S_REGIME;
                end
                S_REGIME: begin
                    if (cur_bit == run_bit) begin
                        run_q <= run_d;
                        if (last) begin
                            k_out   <= regime_k(run_bit, run_d);
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q - 5'd1;
                        end
                    end else begin
                        k_out <= regime_k(run_bit, run_q);
                        if (last) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q - 5'd1;
                            state_q <= S_EXP;
                        end
                    end
                end
                S_EXP: begin
                    exp_out[2'd2 - ecnt_q] <= cur_bit;
                    ecnt_q <= ecnt_q + 2'd1;
                    if (last) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - 5'd1;
                        if (ecnt_q == 2'd2) begin
                            state_q <= S_MANT;
                        end
                    end
                end
                S_MANT: begin
                    mantissa_out[mptr_q] <= cur_bit;
                    mptr_q <= mptr_q - 5'd1;
                    if (last) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - 5'd1;
                    end
                end
                S_DONE: begin
                    if (hold_q) begin
                        hold_q <= 1'b0;
                    end else if (!done) begin
                        done <= 1'b1;
                    end else if (received) begin
                        done    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_posit_decoder.sv
// Randomized bench for posit_decoder with a reference
// decoder and a round-trip encoder model.
module tb_posit_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        received;
    logic [31:0] posit_in;
    logic        sign_out;
    logic signed [5:0] k_out;
    logic [2:0]  exp_out;
    logic [31:0] mantissa_out;
    logic        is_zero;
    logic        is_nar;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        s;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] m;
    } dec_t;

    always #5 clk = ~clk;

    posit_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .received     (received),
        .posit_in     (posit_in),
        .sign_out     (sign_out),
        .k_out        (k_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .is_zero      (is_zero),
        .is_nar       (is_nar),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: measure regime run, then read the rest by shifting.
    function automatic dec_t model(input logic [31:0] w);
        dec_t d;
        int r;
        int used;
        logic [31:0] body;
        logic rb;
        d.s = w[31];
        rb = w[30];
        r = 0;
        while (r < 31 && w[30-r] == rb) r++;
        d.k = rb ? 6'(r - 1) : 6'(-r);
        used = (r < 31) ? r + 1 : 31;
        body = {w[30:0], 1'b0} << used;
        d.e = body[31:29];
        d.m = body << 3;
        return d;
    endfunction

    // Encoder: regime string, exponent, fraction, truncated to 31 bits.
    function automatic logic [31:0] enc(input dec_t d);
        logic [127:0] s;
        int p;
        int kk;
        s = '0;
        p = 127;
        kk = int'($signed(d.k));
        if (kk >= 0) begin
            for (int i = 0; i <= kk; i++) begin s[p] = 1'b1; p--; end
            s[p] = 1'b0; p--;
        end else begin
            for (int i = 0; i < -kk; i++) begin s[p] = 1'b0; p--; end
            s[p] = 1'b1; p--;
        end
        for (int i = 2; i >= 0; i--) begin s[p] = d.e[i]; p--; end
        for (int i = 31; i >= 0; i--) begin s[p] = d.m[i]; p--; end
        return {d.s, s[127:97]};
    endfunction

    task automatic run_decode(input logic [31:0] w, input bit noisy,
                              input bit rt);
        int n;
        bit special;
        dec_t ex;
        dec_t ob;
        special = (w[30:0] == 31'd0);
        ex = special ? dec_t'(0) : model(w);
        @(negedge clk);
        posit_in = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        posit_in = $urandom;
        n = 0;
        while (!done && n < 100) begin
            if (noisy) begin
                start = 1'($urandom);
                received = 1'b1;
                posit_in = $urandom;
            end
            @(posedge clk);
            n++;
            #1;
        end
        start = 1'b0;
        chk("latency", n, special ? 2 : 33);
        chk("sign", {31'd0, sign_out}, {31'd0, ex.s});
        chk("k", {26'd0, k_out}, {26'd0, ex.k});
        chk("exp", {29'd0, exp_out}, {29'd0, ex.e});
        chk("mant", mantissa_out, ex.m);
        chk("flags", {30'd0, is_zero, is_nar},
            {30'd0, w == 32'h0, w == 32'h8000_0000});
        if (rt && !special) begin
            ob = {sign_out, k_out, exp_out, mantissa_out};
            chk("roundtrip", enc(ob), w);
        end
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
        chk("done_clr", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0;
        start = 1'b0;
        received = 1'b0;
        posit_in = '0;
        #2;
        chk("rst_out", {sign_out, k_out, exp_out, is_zero, is_nar, done},
            32'd0);
        chk("rst_mant", mantissa_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_decode(32'h40A0_0000, 1'b0, 1'b1);
        chk("m_40A", mantissa_out, 32'h2800_0000);
        @(posedge clk);
        #1;
        chk("idle_hold", mantissa_out, 32'h2800_0000);
        run_decode(32'hC800_0000, 1'b0, 1'b1);
        chk("e_C80", {29'd0, exp_out}, 32'd2);
        run_decode(32'h0000_0001, 1'b0, 1'b1);
        chk("k_001", {26'd0, k_out}, {26'd0, 6'h22});
        run_decode(32'h7FFF_FFFF, 1'b0, 1'b1);
        chk("k_7FF", {26'd0, k_out}, 32'd30);
        run_decode(32'h7FFF_FFFE, 1'b0, 1'b1);
        chk("k_7FE", {26'd0, k_out}, 32'd29);
        run_decode(32'h0000_0000, 1'b0, 1'b0);
        chk("zero", {31'd0, is_zero}, 32'd1);
        run_decode(32'h8000_0000, 1'b0, 1'b0);
        chk("nar", {31'd0, is_nar}, 32'd1);

        // Reset in the middle of a decode
        @(negedge clk);
        posit_in = 32'h5A5A_1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst", {sign_out, k_out, exp_out, is_zero, is_nar, done},
            32'd0);
        chk("mid_rst_m", mantissa_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_decode(32'h5A5A_1234, 1'b0, 1'b1);

        // Busy-time noise on start, received and posit_in
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            if (w[30:0] == 31'd0) w = w | 32'd1;
            run_decode(w, 1'b1, 1'b1);
        end

        for (int i = 0; i < 1400; i++) begin
            w = $urandom;
            if (w[30:0] == 31'd0) w = w | 32'd1;
            run_decode(w, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
